// File: rtl/uart_loopback_fifo.sv
// RX-to-TX elastic byte buffer: a circular FIFO filled on rx_done and drained
// into the UART transmitter one byte at a time by a small start/busy/done sequencer.
module uart_loopback_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    rx_done,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              ovf_q, ovf_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              pop_s, wr_s, drop_s;

    assign empty    = (count_q == {CW{1'b0}});
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    // A pop frees a slot in the same cycle, so a write into a full FIFO is accepted then.
    assign pop_s  = (state_q == ST_IDLE) && !empty && !tx_busy;
    assign wr_s   = rx_done && (!full || pop_s);
    assign drop_s = rx_done && full && !pop_s;

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) state_d = ST_LAUNCH;
                else       state_d = ST_IDLE;
            end
            ST_LAUNCH:    state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy)      state_d = ST_WAIT_DONE;
                else if (tx_done) state_d = ST_IDLE;
                else              state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_DONE: begin
                if (tx_done) state_d = ST_IDLE;
                else         state_d = ST_WAIT_DONE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Pointer, count, overflow and output-register next values
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        tx_data_d  = tx_data_q;
        tx_start_d = (state_d == ST_LAUNCH);
        if (wr_s) wptr_d = wptr_q + AW'(1);
        else      wptr_d = wptr_q;
        if (pop_s) begin
            rptr_d    = rptr_q + AW'(1);
            tx_data_d = mem_q[rptr_q];
        end else begin
            rptr_d    = rptr_q;
            tx_data_d = tx_data_q;
        end
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Setting has priority so a drop coinciding with a clear is never lost.
        if (drop_s)       ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wptr_q     <= {AW{1'b0}};
            rptr_q     <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (reset && wr_s) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed-plus-random bench for uart_loopback_fifo: a queue scoreboard and a
// simple transmitter model check byte order, handshake and flag behaviour.
module tb_uart_loopback_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic [4:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          ovf_clr;

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0] exp_q[$];
    int tx_hold, tx_len, tx_phase, tx_cnt, nstart, tx_rand;

    always #5 clk = ~clk;

    uart_loopback_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .count(count), .empty(empty), .full(full), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, run the transmitter model, clear pulses.
    task automatic step();
        @(negedge clk);
        rx_done = 1'b0;
        ovf_clr = 1'b0;
        tx_done = 1'b0;
        if (tx_start === 1'b1) begin
            nstart++;
            check("start_while_busy", 32'(tx_busy), 32'd0);
            if (exp_q.size() != 0) check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            else                   check("start_queue_nonempty", 32'(exp_q.size()), 32'd1);
            tx_phase = 1;
            if (tx_rand != 0) tx_len = int'($urandom_range(3, 12));
        end else if (tx_phase == 1) begin
            tx_busy  = 1'b1;
            tx_phase = 2;
            tx_cnt   = 0;
        end else if (tx_phase == 2) begin
            tx_cnt++;
            if (tx_cnt >= tx_len) begin
                tx_busy  = 1'b0;
                tx_done  = 1'b1;
                tx_phase = 0;
            end
        end
        if (tx_hold != 0) tx_busy = 1'b1;
    endtask

    // Present a byte for the next edge; the scoreboard drops it only when the FIFO is full and held.
    task automatic wr(input logic [DW-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        if (!(tx_hold != 0 && exp_q.size() >= DEPTH)) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && tx_phase == 0 && count === 5'd0) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;
        ovf_clr = 1'b0; tx_hold = 0; tx_len = 20; tx_phase = 0; tx_cnt = 0; nstart = 0; tx_rand = 0;

        // Reset held three cycles with rx_done pulsing
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(8'h3C + i);
            rx_done = 1'b1;
            step();
            check("rst_count", 32'(count), 32'd0);
            check("rst_empty", 32'(empty), 32'd1);
            check("rst_ovf", 32'(overflow), 32'd0);
            check("rst_start", 32'(tx_start), 32'd0);
        end
        reset = 1'b1;
        step();
        check("post_rst_tx_data", 32'(tx_data), 32'd0);
        check("post_rst_full", 32'(full), 32'd0);

        // Single byte: tx_start two edges after rx_done
        n0 = nstart;
        wr(8'hA5);
        step();
        check("lat_e0_start", 32'(tx_start), 32'd0);
        check("lat_e0_count", 32'(count), 32'd1);
        step();
        check("lat_e1_start", 32'(tx_start), 32'd1);
        check("lat_e1_data", 32'(tx_data), 32'hA5);
        wait_drain("single_drain", 200);
        check("single_pulses", 32'(nstart - n0), 32'd1);

        // Ordering and pointer wrap with a 10-cycle transmitter
        tx_len = 10;
        n0 = nstart;
        for (int i = 0; i < 20; i++) begin
            wr(8'(i));
            repeat (4) step();
        end
        wait_drain("wrap_drain", 2000);
        check("wrap_pulses", 32'(nstart - n0), 32'd20);
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_ovf", 32'(overflow), 32'd0);

        // Random bytes, random gaps, random frame lengths
        tx_rand = 1;
        n0 = nstart;
        begin
            int nw;
            nw = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 2) == 0 && exp_q.size() < DEPTH) begin
                    wr(8'($urandom));
                    nw++;
                end
                step();
            end
            wait_drain("rand_drain", 2000);
            check("rand_pulses", 32'(nstart - n0), 32'(nw));
        end
        check("rand_ovf", 32'(overflow), 32'd0);
        tx_rand = 0;

        // Overflow: 17 writes with the transmitter held busy
        tx_hold = 1;
        step();
        for (int i = 0; i < 17; i++) begin
            wr(8'(8'h40 + i));
            step();
            if (i == 15) begin
                check("ovf_full16", 32'(full), 32'd1);
                check("ovf_ovf16", 32'(overflow), 32'd0);
            end
        end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        n0 = nstart;
        tx_hold = 0;
        tx_busy = 1'b0;
        wait_drain("ovf_drain", 2000);
        check("ovf_pulses", 32'(nstart - n0), 32'd16);
        check("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Fill again, then a drop coinciding with ovf_clr: set wins
        tx_hold = 1;
        step();
        for (int i = 0; i < 16; i++) begin
            wr(8'(8'h50 + i));
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        wr(8'hEE);
        ovf_clr = 1'b1;
        step();
        check("set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        check("clr_again", 32'(overflow), 32'd0);

        // Write on the same edge as the pop while full
        n0 = nstart;
        tx_hold = 0;
        tx_busy = 1'b0;
        wr(8'h77);
        step();
        check("wp_count", 32'(count), 32'd16);
        check("wp_ovf", 32'(overflow), 32'd0);
        check("wp_start", 32'(tx_start), 32'd1);
        wait_drain("wp_drain", 2000);
        check("wp_pulses", 32'(nstart - n0), 32'd17);

        // Reset during WAIT_DONE with five bytes queued
        tx_len = 30;
        for (int i = 0; i < 6; i++) begin
            wr(8'(8'h90 + i));
            step();
        end
        repeat (6) step();
        check("mid_count", 32'(count), 32'd5);
        reset = 1'b0;
        step();
        check("mid_rst_start", 32'(tx_start), 32'd0);
        step();
        check("mid_rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        n0 = nstart;
        repeat (60) step();
        check("mid_no_start", 32'(nstart - n0), 32'd0);
        wr(8'hC3);
        step();
        step();
        check("mid_restart", 32'(tx_start), 32'd1);
        wait_drain("mid_drain", 500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_loopback_fifo.md
# uart_loopback_fifo

Byte buffer and transmit sequencer between the UART receiver and transmitter. Captures each received byte on its `rx_done` pulse into a circular FIFO. Drains the FIFO into the transmitter one byte at a time through the transmitter's `start`/`tx_busy`/`tx_done` handshake. Used as the echo/loopback path and as the generic RX-to-TX elastic buffer in the UART subsystem.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `DATA_W`, default 8: byte width; must match the UART data width.
- `clk`  in  1  system clock; one clock for the whole block.
- `reset`  in  1  reset; synchronous and active-low (`reset==0` at a `clk` rising edge resets all state).
- `rx_data`  in  DATA_W  received byte; valid only in the cycle `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse from the receiver; write request.
- `tx_start`  out  1  one-cycle pulse to the transmitter `start`.
- `tx_data`  out  DATA_W  byte to transmit; registered; stable from the `tx_start` cycle until the next pop.
- `tx_busy`  in  1  transmitter busy.
- `tx_done`  in  1  transmitter one-cycle completion pulse.
- `count`  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `empty`  out  1  `count==0`.
- `full`  out  1  `count==DEPTH`.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- **Storage:** DEPTH×DATA_W array; write pointer `wptr` and read pointer `rptr`, each $clog2(DEPTH) bits.
  - Pointers wrap naturally, DEPTH-1 → 0.
  - `count` is a separate register, not derived from the pointers.
- **Write:** when `rx_done`=1 and (`!full` or a pop occurs in the same cycle):
  - `mem[wptr] <= rx_data`, `wptr++`.
- **Drop:** when `rx_done`=1 and `full` and there is no pop that cycle:
  - The byte is dropped, pointers are unchanged, and `overflow <= 1`.
- **`overflow` register:**
  - `ovf_clr` clears it.
  - If a set and `ovf_clr` occur in the same cycle, set wins.
- **Pop:** occurs only in the IDLE→LAUNCH transition.
  - `tx_data <= mem[rptr]`, `rptr++`.
- **Count update:** +1 on write only, −1 on pop only, unchanged on write+pop.
- **Sequencer FSM:** four states, IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `!empty` and `!tx_busy`, pop and go to LAUNCH; otherwise stay.
  - LAUNCH: `tx_start`=1 for this single cycle; go to WAIT_BUSY unconditionally.
  - WAIT_BUSY: if `tx_busy`=1, go to WAIT_DONE. If `tx_done`=1 arrives first, go to IDLE (the transmitter finished within the window).
  - WAIT_DONE: on `tx_done`=1, go to IDLE.
  - `tx_start` is a registered decode: high exactly while the state is LAUNCH.
- **Reset values:**
  - State IDLE; `wptr`=`rptr`=0; `count`=0.
  - Outputs: `empty`=1, `full`=0, `overflow`=0, `tx_start`=0, `tx_data`=0.
  - Memory contents are not reset.
- **Reset mid-operation:**
  - All buffered bytes are discarded.
  - `tx_start` is low on the first cycle after reset.
  - An in-flight transmitter frame is not aborted by this block.

## Timing
- All outputs are registered and update on the `clk` rising edge.
- **Write-to-launch latency:**
  - `rx_done` sampled at edge E0 into an empty FIFO with the FSM in IDLE and `tx_busy`=0.
  - `count`=1 after E0; pop at E1; `tx_start`=1 and `tx_data` valid during the cycle after E1.
  - Total: `tx_start` rises 2 edges after `rx_done`.
- **Back-to-back bytes:** the next `tx_start` occurs no earlier than 2 edges after the `tx_done` that returns the FSM to IDLE.
  - `tx_done` at edge D: IDLE after D, pop at D+1, `tx_start` high after D+1.
- **Handshake rules:**
  - `tx_start` is never asserted while `tx_busy`=1.
  - Only one byte is outstanding at a time.
- **Write during pop when full:** accepted with no drop; `count` stays DEPTH.
- `empty` and `full` are combinational decodes of the registered `count`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `rx_done` pulsing → `count`=0, `empty`=1, `overflow`=0, `tx_start`=0 throughout; after release, `tx_data`=0x00.
- **Single byte:** `rx_done` with `rx_data`=0xA5; model `tx_busy` high 1 cycle after `tx_start`, then `tx_done` 20 cycles later → `tx_start` 2 edges after `rx_done`, `tx_data`=0xA5, exactly one `tx_start` pulse, FSM back in IDLE.
- **Ordering and wrap:** write 20 bytes 0x00..0x13 while draining with a 10-cycle transmitter model → output order 0x00..0x13, no drops, pointers wrap, `count` returns to 0.
- **Overflow:** hold `tx_busy`=1 and write 17 bytes with DEPTH=16:
  - `full`=1 after the 16th write; the 17th byte is dropped and `overflow`=1.
  - After releasing the transmitter, 16 bytes drain in order.
  - `ovf_clr` then clears `overflow`.
- **Simultaneous write+pop when full:** `rx_done` on the same edge as the IDLE pop with `count`=16 → `count` stays 16, `overflow` stays 0, and the new byte appears last in order.
- **Reset mid-transfer:** assert reset during WAIT_DONE with 5 bytes queued → `count`=0 after reset; no `tx_start` until a new `rx_done`.
